// File: rtl/vend_controller_if.sv
// Dispense and change-coin handshakes between the vending controller and its drivers.
// The controller side uses the master modport; dispenser/hopper drivers use slave.
interface vend_controller_if #(
  parameter int IDX_W = 3
);
  logic             vend_valid;
  logic [IDX_W-1:0] vend_index;
  logic             vend_ready;
  logic             chg_valid;
  logic [1:0]       chg_type;
  logic             chg_ready;

  modport master (
    output vend_valid, vend_index, chg_valid, chg_type,
    input  vend_ready, chg_ready
  );

  modport slave (
    input  vend_valid, vend_index, chg_valid, chg_type,
    output vend_ready, chg_ready
  );
endinterface

// File: rtl/vend_controller.sv
// N-item vending controller: coin credit, inventory with restock, timeout refund, greedy change.
// Optional card payment in IDLE is enabled by defining CARD_PAY_EN.
module vend_controller #(
  parameter int NUM_ITEMS      = 8,
  parameter int IDX_W          = 3,
  parameter int BAL_W          = 9,
  parameter int INV_W          = 4,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         coin_valid,
  input  logic [1:0]                   coin_type,
  input  logic                         sel_valid,
  input  logic [IDX_W-1:0]             sel_index,
  input  logic                         cancel,
  input  logic [NUM_ITEMS*BAL_W-1:0]   prices,
  input  logic                         restock_valid,
  input  logic [IDX_W-1:0]             restock_index,
  input  logic [INV_W-1:0]             restock_count,
  vend_controller_if.master            hs,
  output logic                         coin_reject,
  output logic                         err_funds,
  output logic                         err_soldout,
  output logic [BAL_W-1:0]             balance,
  output logic [NUM_ITEMS-1:0]         sold_out
`ifdef CARD_PAY_EN
  ,
  input  logic                         card_present,
  input  logic [BAL_W-1:0]             card_balance,
  output logic                         card_debit_valid,
  output logic [BAL_W-1:0]             card_debit_amt
`endif
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [INV_W:0] INV_MAX = (INV_W+1)'((1 << INV_W) - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  state_t             state_reg, state_next;
  logic [BAL_W-1:0]   balance_reg, balance_next;
  logic [TW-1:0]      timer_reg, timer_next;
  logic [IDX_W-1:0]   vend_index_reg, vend_index_next;
  logic [INV_W-1:0]   inv_reg [NUM_ITEMS];
  logic [INV_W-1:0]   inv_next [NUM_ITEMS];
  logic               vend_valid_reg, vend_valid_next;
  logic               chg_valid_reg, chg_valid_next;
  logic [1:0]         chg_type_reg, chg_type_next;
  logic               coin_reject_reg, coin_reject_next;
  logic               err_funds_reg, err_funds_next;
  logic               err_soldout_reg, err_soldout_next;
  logic [NUM_ITEMS-1:0] sold_out_reg;
`ifdef CARD_PAY_EN
  logic               card_take;
  logic               card_debit_valid_reg, card_debit_valid_next;
  logic [BAL_W-1:0]   card_debit_amt_reg, card_debit_amt_next;
`endif

  logic               coin_ok, sel_sold, sel_funds, take_item;
  logic [BAL_W-1:0]   sel_price, change_value;
  logic [INV_W-1:0]   sel_inv;
  logic               sel_in_stock;
  logic [BAL_W:0]     coin_sum;

  function automatic logic [BAL_W-1:0] coin_val(input logic [1:0] t);
    case (t)
      2'b00:   return BAL_W'(5);
      2'b01:   return BAL_W'(10);
      2'b10:   return BAL_W'(25);
      default: return BAL_W'(100);
    endcase
  endfunction

  function automatic logic [1:0] greedy(input logic [BAL_W-1:0] b);
    if (b >= BAL_W'(25))      return 2'b10;
    else if (b >= BAL_W'(10)) return 2'b01;
    else                      return 2'b00;
  endfunction

  always_comb begin
    sel_price = '0;
    sel_inv   = '0;
    for (int i = 0; i < NUM_ITEMS; i++) begin
      if (sel_index == IDX_W'(i)) begin
        sel_price = prices[i*BAL_W +: BAL_W];
        sel_inv   = inv_reg[i];
      end
    end
  end

  assign sel_in_stock = ({1'b0, sel_index} < (IDX_W+1)'(NUM_ITEMS)) && (sel_inv != '0);
  // Carry out of the widened sum means the credit would exceed 2**BAL_W-1.
  assign coin_sum     = {1'b0, balance_reg} + {1'b0, coin_val(coin_type)};
  assign change_value = coin_val(greedy(balance_reg));

  // Restock and vend decrement may hit the same item; sum first, then saturate.
  for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_inv
    logic           add_hit, dec_hit;
    logic [INV_W:0] sum;
    assign add_hit = restock_valid && (restock_index == IDX_W'(gi));
    assign dec_hit = take_item && (sel_index == IDX_W'(gi));
    assign sum = {1'b0, inv_reg[gi]} + (add_hit ? {1'b0, restock_count} : '0)
                 - {{INV_W{1'b0}}, dec_hit};
    assign inv_next[gi] = (sum > INV_MAX) ? INV_MAX[INV_W-1:0] : sum[INV_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg       <= IDLE;
      balance_reg     <= '0;
      timer_reg       <= '0;
      vend_index_reg  <= '0;
      vend_valid_reg  <= 1'b0;
      chg_valid_reg   <= 1'b0;
      chg_type_reg    <= 2'b00;
      coin_reject_reg <= 1'b0;
      err_funds_reg   <= 1'b0;
      err_soldout_reg <= 1'b0;
      sold_out_reg    <= '1;
      for (int i = 0; i < NUM_ITEMS; i++) inv_reg[i] <= '0;
`ifdef CARD_PAY_EN
      card_debit_valid_reg <= 1'b0;
      card_debit_amt_reg   <= '0;
`endif
    end else begin
      state_reg       <= state_next;
      balance_reg     <= balance_next;
      timer_reg       <= timer_next;
      vend_index_reg  <= vend_index_next;
      vend_valid_reg  <= vend_valid_next;
      chg_valid_reg   <= chg_valid_next;
      chg_type_reg    <= chg_type_next;
      coin_reject_reg <= coin_reject_next;
      err_funds_reg   <= err_funds_next;
      err_soldout_reg <= err_soldout_next;
      for (int i = 0; i < NUM_ITEMS; i++) begin
        inv_reg[i]      <= inv_next[i];
        sold_out_reg[i] <= (inv_next[i] == '0);
      end
`ifdef CARD_PAY_EN
      card_debit_valid_reg <= card_debit_valid_next;
      card_debit_amt_reg   <= card_debit_amt_next;
`endif
    end
  end

  always_comb begin
    state_next      = state_reg;
    balance_next    = balance_reg;
    timer_next      = timer_reg;
    vend_index_next = vend_index_reg;
    coin_ok         = 1'b0;
    sel_sold        = 1'b0;
    sel_funds       = 1'b0;
    take_item       = 1'b0;
`ifdef CARD_PAY_EN
    card_take       = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (sel_valid) begin
          if (!sel_in_stock) sel_sold = 1'b1;
`ifdef CARD_PAY_EN
          else if (card_present && (card_balance >= sel_price)) begin
            card_take       = 1'b1;
            take_item       = 1'b1;
            vend_index_next = sel_index;
            state_next      = VEND;
          end
`endif
          else sel_funds = 1'b1;
        end else if (coin_valid && !cancel && !coin_sum[BAL_W]) begin
          coin_ok      = 1'b1;
          balance_next = coin_sum[BAL_W-1:0];
          timer_next   = '0;
          state_next   = COLLECT;
        end
      end
      COLLECT: begin
        if (cancel || (timer_reg == TW'(TIMEOUT_CYCLES - 1))) begin
          state_next = CHANGE;
          timer_next = '0;
        end else if (sel_valid) begin
          timer_next = timer_reg + TW'(1);
          if (!sel_in_stock)               sel_sold  = 1'b1;
          else if (balance_reg < sel_price) sel_funds = 1'b1;
          else begin
            balance_next    = balance_reg - sel_price;
            take_item       = 1'b1;
            vend_index_next = sel_index;
            timer_next      = '0;
            state_next      = VEND;
          end
        end else if (coin_valid && !coin_sum[BAL_W]) begin
          coin_ok      = 1'b1;
          balance_next = coin_sum[BAL_W-1:0];
          timer_next   = '0;
        end else begin
          timer_next = timer_reg + TW'(1);
        end
      end
      VEND: begin
        if (vend_valid_reg && hs.vend_ready)
          state_next = (balance_reg != '0) ? CHANGE : IDLE;
      end
      default: begin
        if (balance_reg == '0) begin
          state_next = IDLE;
        end else if (chg_valid_reg && hs.chg_ready) begin
          balance_next = balance_reg - change_value;
          if (balance_next == '0) state_next = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    vend_valid_next  = (state_next == VEND);
    chg_valid_next   = (state_next == CHANGE);
    chg_type_next    = (state_next == CHANGE) ? greedy(balance_next) : 2'b00;
    coin_reject_next = coin_valid && !coin_ok;
    err_funds_next   = sel_funds;
    err_soldout_next = sel_sold;
`ifdef CARD_PAY_EN
    card_debit_valid_next = card_take;
    card_debit_amt_next   = card_take ? sel_price : '0;
`endif
  end

  assign hs.vend_valid = vend_valid_reg;
  assign hs.vend_index = vend_index_reg;
  assign hs.chg_valid  = chg_valid_reg;
  assign hs.chg_type   = chg_type_reg;
  assign coin_reject   = coin_reject_reg;
  assign err_funds     = err_funds_reg;
  assign err_soldout   = err_soldout_reg;
  assign balance       = balance_reg;
  assign sold_out      = sold_out_reg;
`ifdef CARD_PAY_EN
  assign card_debit_valid = card_debit_valid_reg;
  assign card_debit_amt   = card_debit_amt_reg;
`endif
endmodule

// File: tb/tb_vend_controller.sv
// Directed bench for vend_controller: per-cycle vector table plus hand-written
// sequences for refund/reset, timeout, saturation and (if built) card payment.
module tb_vend_controller;
  localparam int NUM_ITEMS      = 8;
  localparam int IDX_W          = 3;
  localparam int BAL_W          = 9;
  localparam int INV_W          = 4;
  localparam int TIMEOUT_CYCLES = 40;

  logic                       clk = 1'b0;
  logic                       rst;
  logic                       coin_valid;
  logic [1:0]                 coin_type;
  logic                       sel_valid;
  logic [IDX_W-1:0]           sel_index;
  logic                       cancel;
  logic [NUM_ITEMS*BAL_W-1:0] prices;
  logic                       restock_valid;
  logic [IDX_W-1:0]           restock_index;
  logic [INV_W-1:0]           restock_count;
  logic                       coin_reject, err_funds, err_soldout;
  logic [BAL_W-1:0]           balance;
  logic [NUM_ITEMS-1:0]       sold_out;
`ifdef CARD_PAY_EN
  logic                       card_present;
  logic [BAL_W-1:0]           card_balance;
  logic                       card_debit_valid;
  logic [BAL_W-1:0]           card_debit_amt;
`endif

  vend_controller_if #(.IDX_W(IDX_W)) hs_if ();

  vend_controller #(
    .NUM_ITEMS(NUM_ITEMS), .IDX_W(IDX_W), .BAL_W(BAL_W),
    .INV_W(INV_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .coin_valid(coin_valid), .coin_type(coin_type),
    .sel_valid(sel_valid), .sel_index(sel_index), .cancel(cancel),
    .prices(prices),
    .restock_valid(restock_valid), .restock_index(restock_index),
    .restock_count(restock_count),
    .hs(hs_if),
    .coin_reject(coin_reject), .err_funds(err_funds), .err_soldout(err_soldout),
    .balance(balance), .sold_out(sold_out)
`ifdef CARD_PAY_EN
    , .card_present(card_present), .card_balance(card_balance),
    .card_debit_valid(card_debit_valid), .card_debit_amt(card_debit_amt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string            name;
    logic             coin_valid;
    logic [1:0]       coin_type;
    logic             sel_valid;
    logic [IDX_W-1:0] sel_index;
    logic             cancel;
    logic             rs_valid;
    logic [IDX_W-1:0] rs_index;
    logic [INV_W-1:0] rs_count;
    logic             vend_ready;
    logic             chg_ready;
    logic [BAL_W-1:0] bal;
    logic             vv;
    logic [IDX_W-1:0] vi;
    logic             cv;
    logic [1:0]       ct;
    logic             rej;
    logic             ef;
    logic             es;
    logic [NUM_ITEMS-1:0] so;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   price_tab [NUM_ITEMS] = '{50, 75, 65, 40, 505, 25, 10, 5};

  function automatic vec_t mk(string n, int c, int ct_in, int s, int si, int ca,
                              int rv, int ri, int rc, int vr, int cr,
                              int bal, int vv, int vi, int cv, int cht,
                              int rej, int ef, int es, int so);
    vec_t v;
    v.name = n;
    v.coin_valid = c[0];       v.coin_type = ct_in[1:0];
    v.sel_valid = s[0];        v.sel_index = si[IDX_W-1:0];
    v.cancel = ca[0];
    v.rs_valid = rv[0];        v.rs_index = ri[IDX_W-1:0];
    v.rs_count = rc[INV_W-1:0];
    v.vend_ready = vr[0];      v.chg_ready = cr[0];
    v.bal = bal[BAL_W-1:0];    v.vv = vv[0];
    v.vi = vi[IDX_W-1:0];      v.cv = cv[0];
    v.ct = cht[1:0];           v.rej = rej[0];
    v.ef = ef[0];              v.es = es[0];
    v.so = so[NUM_ITEMS-1:0];
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int bal, input int vv, input int vi,
                            input int cv, input int ct, input int rej, input int ef,
                            input int es, input int so);
    check({tag, ".balance"},     32'(balance),           32'(bal));
    check({tag, ".vend_valid"},  32'(hs_if.vend_valid),  32'(vv));
    check({tag, ".vend_index"},  32'(hs_if.vend_index),  32'(vi));
    check({tag, ".chg_valid"},   32'(hs_if.chg_valid),   32'(cv));
    check({tag, ".chg_type"},    32'(hs_if.chg_type),    32'(ct));
    check({tag, ".coin_reject"}, 32'(coin_reject),       32'(rej));
    check({tag, ".err_funds"},   32'(err_funds),         32'(ef));
    check({tag, ".err_soldout"}, 32'(err_soldout),       32'(es));
    check({tag, ".sold_out"},    32'(sold_out),          32'(so));
    $display("vec %-20s bal=%0d vv=%0b vi=%0d cv=%0b ct=%0d rej=%0b ef=%0b es=%0b so=%02h",
             tag, balance, hs_if.vend_valid, hs_if.vend_index, hs_if.chg_valid,
             hs_if.chg_type, coin_reject, err_funds, err_soldout, sold_out);
  endtask

  task automatic idle_in();
    coin_valid = 1'b0; coin_type = 2'b00;
    sel_valid = 1'b0;  sel_index = '0; cancel = 1'b0;
    restock_valid = 1'b0; restock_index = '0; restock_count = '0;
    hs_if.vend_ready = 1'b0; hs_if.chg_ready = 1'b0;
`ifdef CARD_PAY_EN
    card_present = 1'b0; card_balance = '0;
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < NUM_ITEMS; i++) prices[i*BAL_W +: BAL_W] = BAL_W'(price_tab[i]);
    idle_in();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 0, 0, 0, 0, 0, 0, 0, 0, 8'hFF);
    rst = 1'b1;

    //                   name              c ct s si ca rv ri rc vr cr  bal vv vi cv ct rj ef es so
    vecs.push_back(mk("restock2",          0,0, 0,0, 0, 1,2,5, 0,0,    0,0,0, 0,0, 0,0,0, 8'hFB));
    vecs.push_back(mk("sel_empty_idle",    0,0, 1,0, 0, 0,0,0, 0,0,    0,0,0, 0,0, 0,0,1, 8'hFB));
    vecs.push_back(mk("sel_nofund_idle",   0,0, 1,2, 0, 0,0,0, 0,0,    0,0,0, 0,0, 0,1,0, 8'hFB));
    vecs.push_back(mk("coin_q1",           1,2, 0,0, 0, 0,0,0, 0,0,   25,0,0, 0,0, 0,0,0, 8'hFB));
    vecs.push_back(mk("coin_q2",           1,2, 0,0, 0, 0,0,0, 0,0,   50,0,0, 0,0, 0,0,0, 8'hFB));
    vecs.push_back(mk("coin_d1",           1,1, 0,0, 0, 0,0,0, 0,0,   60,0,0, 0,0, 0,0,0, 8'hFB));
    vecs.push_back(mk("coin_d2",           1,1, 0,0, 0, 0,0,0, 0,0,   70,0,0, 0,0, 0,0,0, 8'hFB));
    vecs.push_back(mk("sel2_vend",         0,0, 1,2, 0, 0,0,0, 0,0,    5,1,2, 0,0, 0,0,0, 8'hFB));
    vecs.push_back(mk("vend_wait",         0,0, 0,0, 0, 0,0,0, 0,0,    5,1,2, 0,0, 0,0,0, 8'hFB));
    vecs.push_back(mk("vend_ack",          0,0, 0,0, 0, 0,0,0, 1,0,    5,0,2, 1,0, 0,0,0, 8'hFB));
    vecs.push_back(mk("chg_wait_n",        0,0, 0,0, 0, 0,0,0, 0,0,    5,0,2, 1,0, 0,0,0, 8'hFB));
    vecs.push_back(mk("chg_nickel",        0,0, 0,0, 0, 0,0,0, 0,1,    0,0,2, 0,0, 0,0,0, 8'hFB));
    vecs.push_back(mk("idle_after",        0,0, 0,0, 0, 0,0,0, 0,0,    0,0,2, 0,0, 0,0,0, 8'hFB));
    vecs.push_back(mk("restock3",          0,0, 0,0, 0, 1,3,2, 0,0,    0,0,2, 0,0, 0,0,0, 8'hF3));
    vecs.push_back(mk("coin_dollar",       1,3, 0,0, 0, 0,0,0, 0,0,  100,0,2, 0,0, 0,0,0, 8'hF3));
    vecs.push_back(mk("sel3_vend",         0,0, 1,3, 0, 0,0,0, 0,0,   60,1,3, 0,0, 0,0,0, 8'hF3));
    vecs.push_back(mk("coin_in_vend",      1,2, 0,0, 0, 0,0,0, 0,0,   60,1,3, 0,0, 1,0,0, 8'hF3));
    vecs.push_back(mk("vend_ack2",         0,0, 0,0, 0, 0,0,0, 1,0,   60,0,3, 1,2, 0,0,0, 8'hF3));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk("chg_hold",        0,0, 0,0, 0, 0,0,0, 0,0,   60,0,3, 1,2, 0,0,0, 8'hF3));
    vecs.push_back(mk("chg_q1",            0,0, 0,0, 0, 0,0,0, 0,1,   35,0,3, 1,2, 0,0,0, 8'hF3));
    vecs.push_back(mk("chg_q2",            0,0, 0,0, 0, 0,0,0, 0,1,   10,0,3, 1,1, 0,0,0, 8'hF3));
    vecs.push_back(mk("chg_d",             0,0, 0,0, 0, 0,0,0, 0,1,    0,0,3, 0,0, 0,0,0, 8'hF3));
    for (int k = 1; k <= 5; k++)
      vecs.push_back(mk("coin_dollar_n",   1,3, 0,0, 0, 0,0,0, 0,0, 100*k,0,3, 0,0, 0,0,0, 8'hF3));
    vecs.push_back(mk("coin_overflow",     1,3, 0,0, 0, 0,0,0, 0,0,  500,0,3, 0,0, 1,0,0, 8'hF3));
    vecs.push_back(mk("sel_empty_rs4",     0,0, 1,0, 0, 1,4,1, 0,0,  500,0,3, 0,0, 0,0,1, 8'hE3));
    vecs.push_back(mk("sel_underfund",     0,0, 1,4, 0, 0,0,0, 0,0,  500,0,3, 0,0, 0,1,0, 8'hE3));
    vecs.push_back(mk("cancel_w_coin",     1,1, 0,0, 1, 0,0,0, 0,0,  500,0,3, 1,2, 1,0,0, 8'hE3));

    foreach (vecs[i]) begin
      coin_valid = vecs[i].coin_valid;  coin_type = vecs[i].coin_type;
      sel_valid = vecs[i].sel_valid;    sel_index = vecs[i].sel_index;
      cancel = vecs[i].cancel;
      restock_valid = vecs[i].rs_valid; restock_index = vecs[i].rs_index;
      restock_count = vecs[i].rs_count;
      hs_if.vend_ready = vecs[i].vend_ready;
      hs_if.chg_ready = vecs[i].chg_ready;
      step();
      check_outs(vecs[i].name, int'(vecs[i].bal), int'(vecs[i].vv), int'(vecs[i].vi),
                 int'(vecs[i].cv), int'(vecs[i].ct), int'(vecs[i].rej), int'(vecs[i].ef),
                 int'(vecs[i].es), int'(vecs[i].so));
    end
    check("inv2_after_vend", 32'(dut.inv_reg[2]), 32'd4);
    check("inv3_after_vend", 32'(dut.inv_reg[3]), 32'd1);

    // Refund 500 in quarters, then reset in the middle of the change sequence.
    idle_in();
    hs_if.chg_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("refund_bal", 32'(balance), 32'(500 - 25 * k));
      check("refund_type", 32'(hs_if.chg_type), 32'd2);
    end
    rst = 1'b0;
    step();
    check_outs("rst_mid_change", 0, 0, 0, 0, 0, 0, 0, 0, 8'hFF);
    idle_in();
    rst = 1'b1;
    step();

    // Plain timeout: one quarter back after TIMEOUT_CYCLES idle cycles.
    coin_valid = 1'b1; coin_type = 2'b10;
    step();
    check("to_coin_bal", 32'(balance), 32'd25);
    idle_in();
    repeat (TIMEOUT_CYCLES - 1) step();
    check("to_not_yet", 32'(hs_if.chg_valid), 32'd0);
    step();
    check_outs("to_fired", 25, 0, 0, 1, 2, 0, 0, 0, 8'hFF);
    hs_if.chg_ready = 1'b1;
    step();
    check_outs("to_refunded", 0, 0, 0, 0, 0, 0, 0, 0, 8'hFF);
    idle_in();

    // A coin mid-wait restarts the timer.
    coin_valid = 1'b1; coin_type = 2'b10;
    step();
    idle_in();
    repeat (15) step();
    coin_valid = 1'b1; coin_type = 2'b00;
    step();
    check("tr_coin_bal", 32'(balance), 32'd30);
    idle_in();
    repeat (TIMEOUT_CYCLES - 1) step();
    check("tr_not_yet", 32'(hs_if.chg_valid), 32'd0);
    step();
    check_outs("tr_fired", 30, 0, 0, 1, 2, 0, 0, 0, 8'hFF);
    hs_if.chg_ready = 1'b1;
    step();
    check_outs("tr_chg_q", 5, 0, 0, 1, 0, 0, 0, 0, 8'hFF);
    step();
    check_outs("tr_chg_n", 0, 0, 0, 0, 0, 0, 0, 0, 8'hFF);
    idle_in();

    // Restock of 15 onto 14 with a same-cycle vend of that item saturates at 15.
    restock_valid = 1'b1; restock_index = 3'd5; restock_count = 4'd14;
    step();
    check("sat_pre_inv", 32'(dut.inv_reg[5]), 32'd14);
    idle_in();
    coin_valid = 1'b1; coin_type = 2'b10;
    step();
    idle_in();
    sel_valid = 1'b1; sel_index = 3'd5;
    restock_valid = 1'b1; restock_index = 3'd5; restock_count = 4'd15;
    step();
    check_outs("sat_vend", 0, 1, 5, 0, 0, 0, 0, 0, 8'hDF);
    check("sat_inv", 32'(dut.inv_reg[5]), 32'd15);
    idle_in();
    hs_if.vend_ready = 1'b1;
    step();
    check_outs("sat_ack", 0, 0, 5, 0, 0, 0, 0, 0, 8'hDF);
    idle_in();
    step();
    check("sat_no_change", 32'(hs_if.chg_valid), 32'd0);

`ifdef CARD_PAY_EN
    restock_valid = 1'b1; restock_index = 3'd1; restock_count = 4'd1;
    step();
    idle_in();
    card_present = 1'b1; card_balance = 9'd100;
    sel_valid = 1'b1; sel_index = 3'd1;
    step();
    check("card_debit_valid", 32'(card_debit_valid), 32'd1);
    check("card_debit_amt", 32'(card_debit_amt), 32'd75);
    check_outs("card_vend", 0, 1, 1, 0, 0, 0, 0, 0, 8'hDF);
    idle_in();
    hs_if.vend_ready = 1'b1;
    step();
    check("card_debit_pulse", 32'(card_debit_valid), 32'd0);
    check_outs("card_ack", 0, 0, 1, 0, 0, 0, 0, 0, 8'hDF);
    idle_in();
    step();
    check("card_no_change", 32'(hs_if.chg_valid), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
